cvita_hdr_framer: RTL and testbench

CVITA_HDR_FRAMER -- requirements
Module: cvita_hdr_framer

---
 rtl/cvita_hdr_framer.sv | 140 ++++++++++++++
 tb/tb_cvita_hdr_framer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvita_hdr_framer.sv
// CVITA framer: turns a header descriptor plus a payload AXI-Stream into a framed
// CVITA packet (header word, optional timestamp word, then the payload beats).
module cvita_hdr_framer #(
    parameter logic [11:0] SEQ_INIT = 12'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [1:0]  hdr_pkt_type,
    input  logic        hdr_eob,
    input  logic        hdr_has_time,
    input  logic [15:0] hdr_src_sid,
    input  logic [15:0] hdr_dst_sid,
    input  logic [63:0] hdr_vita_time,
    input  logic [15:0] hdr_payload_length,
    input  logic        hdr_tvalid,
    output logic        hdr_tready,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);
    localparam int unsigned SEQ_W = 12;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned SID_W = 16;
    localparam int unsigned DAT_W = 64;

    typedef enum logic [1:0] {IDLE, HDR, TIME, BODY} state_t;

    state_t             state_q, state_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [1:0]         type_q, type_d;
    logic               eob_q, eob_d;
    logic               has_time_q, has_time_d;
    logic [SID_W-1:0]   src_q, src_d;
    logic [SID_W-1:0]   dst_q, dst_d;
    logic [DAT_W-1:0]   time_q, time_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic hdr_fire;
    assign hdr_fire = hdr_tvalid && hdr_tready;

    // Next-state: descriptor capture, word sequencing and seqnum bookkeeping.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        type_d     = type_q;
        eob_d      = eob_q;
        has_time_d = has_time_q;
        src_d      = src_q;
        dst_d      = dst_q;
        time_d     = time_q;
        len_d      = len_q;
        case (state_q)
            IDLE: begin
                if (hdr_fire) begin
                    type_d     = hdr_pkt_type;
                    eob_d      = hdr_eob;
                    has_time_d = hdr_has_time;
                    src_d      = hdr_src_sid;
                    dst_d      = hdr_dst_sid;
                    time_d     = hdr_vita_time;
                    len_d      = hdr_payload_length +
                                 (hdr_has_time ? LEN_W'(16) : LEN_W'(8));
                    state_d    = HDR;
                end
            end
            HDR: begin
                if (o_tready) begin
                    state_d = has_time_q ? TIME : BODY;
                    seq_d   = seq_q + SEQ_W'(1);
                end
            end
            TIME: begin
                if (o_tready) state_d = BODY;
            end
            BODY: begin
                if (i_tvalid && o_tready && i_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A restart request wins over the header-handshake increment.
        if (clear) seq_d = SEQ_INIT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            seq_q      <= SEQ_INIT;
            type_q     <= '0;
            eob_q      <= 1'b0;
            has_time_q <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            time_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            type_q     <= type_d;
            eob_q      <= eob_d;
            has_time_q <= has_time_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            time_q     <= time_d;
            len_q      <= len_d;
        end
    end

    // Header/time words come from held registers; payload is a straight pass-through.
    always_comb begin
        hdr_tready = 1'b0;
        i_tready   = 1'b0;
        o_tvalid   = 1'b0;
        o_tlast    = 1'b0;
        o_tdata    = '0;
        case (state_q)
            IDLE: hdr_tready = reset_n;
            HDR: begin
                o_tvalid = 1'b1;
                o_tdata  = {type_q, has_time_q, eob_q, seq_q, len_q, src_q, dst_q};
            end
            TIME: begin
                o_tvalid = 1'b1;
                o_tdata  = time_q;
            end
            BODY: begin
                o_tvalid = i_tvalid;
                o_tlast  = i_tlast;
                o_tdata  = i_tdata;
                i_tready = o_tready;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cvita_hdr_framer.sv
// Scoreboard bench for cvita_hdr_framer: queued drivers, expected-beat queue, negedge monitor.
module tb_cvita_hdr_framer;
    localparam logic [11:0] SEQ_INIT = 12'd0;

    typedef struct {
        logic [1:0]  typ;
        logic        eob;
        logic        ht;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] plen;
        logic [63:0] vt;
    } desc_t;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [1:0]  hdr_pkt_type;
    logic        hdr_eob;
    logic        hdr_has_time;
    logic [15:0] hdr_src_sid;
    logic [15:0] hdr_dst_sid;
    logic [63:0] hdr_vita_time;
    logic [15:0] hdr_payload_length;
    logic        hdr_tvalid;
    logic        hdr_tready;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    cvita_hdr_framer #(.SEQ_INIT(SEQ_INIT)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .hdr_pkt_type(hdr_pkt_type), .hdr_eob(hdr_eob), .hdr_has_time(hdr_has_time),
        .hdr_src_sid(hdr_src_sid), .hdr_dst_sid(hdr_dst_sid),
        .hdr_vita_time(hdr_vita_time), .hdr_payload_length(hdr_payload_length),
        .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    desc_t       dq[$];
    beat_t       pq[$];
    beat_t       eq[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [11:0] mseq;
    int          rmode;
    bit          thr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic desc_t mk(input logic [1:0] typ, input logic eob, input logic ht,
                                 input logic [15:0] src, input logic [15:0] dst,
                                 input logic [15:0] plen, input logic [63:0] vt);
        desc_t d;
        d.typ = typ; d.eob = eob; d.ht = ht; d.src = src; d.dst = dst;
        d.plen = plen; d.vt = vt;
        return d;
    endfunction

    // Reference model: a packet is header word, optional time word, then payload beats.
    task automatic send_pkt(input desc_t d, input int nb);
        beat_t b;
        logic [15:0] len;
        len = 16'(int'(d.plen) + (d.ht ? 16 : 8));
        dq.push_back(d);
        b.d = {d.typ, d.ht, d.eob, mseq, len, d.src, d.dst};
        b.l = 1'b0;
        eq.push_back(b);
        if (d.ht) begin
            b.d = d.vt;
            eq.push_back(b);
        end
        for (int i = 0; i < nb; i++) begin
            b.d = {$urandom(), $urandom()};
            b.l = (i == nb - 1);
            pq.push_back(b);
            eq.push_back(b);
        end
        mseq = mseq + 12'd1;
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (eq.size() == 0 && dq.size() == 0 && pq.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d beats still expected", eq.size());
            eq.delete(); pq.delete(); dq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_o_tvalid"},   65'(o_tvalid),   65'(0));
        chk({nm, "_o_tlast"},    65'(o_tlast),    65'(0));
        chk({nm, "_i_tready"},   65'(i_tready),   65'(0));
        chk({nm, "_hdr_tready"}, 65'(hdr_tready), 65'(0));
        chk({nm, "_o_tdata"},    65'(o_tdata),    65'(0));
    endtask

    // Descriptor driver
    initial begin
        bit    hfire;
        desc_t d;
        forever begin
            @(negedge clk);
            hfire = hdr_tvalid && hdr_tready;
            @(posedge clk);
            #1;
            if (hfire) hdr_tvalid = 1'b0;
            if (!hdr_tvalid && dq.size() > 0) begin
                d = dq.pop_front();
                hdr_pkt_type = d.typ; hdr_eob = d.eob; hdr_has_time = d.ht;
                hdr_src_sid = d.src; hdr_dst_sid = d.dst;
                hdr_payload_length = d.plen; hdr_vita_time = d.vt;
                hdr_tvalid = 1'b1;
            end
        end
    end

    // Payload driver, optionally throttling i_tvalid
    initial begin
        bit    pfire;
        beat_t b;
        forever begin
            @(negedge clk);
            pfire = i_tvalid && i_tready;
            @(posedge clk);
            #1;
            if (pfire) i_tvalid = 1'b0;
            if (!i_tvalid && pq.size() > 0 && (!thr || $urandom_range(0, 3) != 0)) begin
                b = pq.pop_front();
                i_tdata = b.d; i_tlast = b.l; i_tvalid = 1'b1;
            end
        end
    end

    // Output back-pressure: 0 = always ready, 1 = random, 2 = left to the main sequence
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) o_tready = 1'b1;
            else if (rmode == 1) o_tready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        bit          stalled = 0;
        logic [63:0] last_d = '0;
        logic        last_l = 1'b0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", 65'(o_tvalid), 65'(1));
                    chk("stall_hold", {o_tlast, o_tdata}, {last_l, last_d});
                end
                if (o_tvalid && o_tready) begin
                    if (eq.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_beat: got %h with no expected beat", o_tdata);
                    end else begin
                        e = eq.pop_front();
                        chk("beat", {o_tlast, o_tdata}, {e.l, e.d});
                    end
                end
                stalled = o_tvalid && !o_tready;
                last_d  = o_tdata;
                last_l  = o_tlast;
            end
        end
    end

    initial begin
        bit got;
        desc_t d;
        reset_n = 1'b0; clear = 1'b0;
        hdr_pkt_type = '0; hdr_eob = 1'b0; hdr_has_time = 1'b0;
        hdr_src_sid = '0; hdr_dst_sid = '0; hdr_vita_time = '0;
        hdr_payload_length = '0; hdr_tvalid = 1'b0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
        rmode = 0; thr = 0; mseq = SEQ_INIT;

        #1;
        chk_outputs_zero("in_reset");
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_hdr_tready", 65'(hdr_tready), 65'(1));
        chk("idle_o_tvalid", 65'(o_tvalid), 65'(0));
        chk("idle_i_tready", 65'(i_tready), 65'(0));
        chk("idle_o_tdata", 65'(o_tdata), 65'(0));

        // Scenario 1: plain packet, header one clock after acceptance
        send_pkt(mk(2'd0, 1'b0, 1'b0, 16'h0010, 16'h0020, 16'd24, 64'd0), 3);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (hdr_tvalid && hdr_tready) begin got = 1; break; end
        end
        chk("s1_hdr_accept", 65'(got), 65'(1));
        @(negedge clk);
        chk("s1_hdr_word", {o_tvalid, o_tdata}, {1'b1, 64'h0000_0020_0010_0020});
        drain(200);

        // Scenario 2: timestamped end-of-burst packet
        send_pkt(mk(2'd1, 1'b1, 1'b1, 16'h1234, 16'h5678, 16'd8, 64'h1122334455667788), 1);
        drain(200);

        // Advance to seqnum 7, then clear coincident with its header handshake
        for (int i = 0; i < 5; i++) send_pkt(mk(2'($urandom()), 1'b0, 1'b0, 16'h1, 16'h2, 16'd8, 64'd0), 1);
        drain(500);
        rmode = 2;
        @(posedge clk);
        #2 o_tready = 1'b0;
        send_pkt(mk(2'd2, 1'b0, 1'b0, 16'hAAAA, 16'hBBBB, 16'd16, 64'd0), 2);
        got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (o_tvalid) begin got = 1; break; end
        end
        chk("s5_hdr_present", 65'(got), 65'(1));
        @(posedge clk);
        #2 o_tready = 1'b1; clear = 1'b1;
        @(posedge clk);
        #2 clear = 1'b0; rmode = 0;
        mseq = SEQ_INIT;
        drain(200);

        // Scenario 3: 4097 single-beat packets walk seqnum through the wrap
        for (int i = 0; i < 4097; i++)
            send_pkt(mk(2'd0, 1'b0, 1'b0, 16'(i), 16'h0F0F, 16'd8, 64'd0), 1);
        drain(40000);

        // Scenario 4: random fields and lengths under random throttling on both sides
        thr = 1; rmode = 1;
        for (int i = 0; i < 40; i++) begin
            d = mk(2'($urandom()), 1'($urandom()), 1'($urandom()), 16'($urandom()),
                   16'($urandom()), 16'($urandom()), {$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) d.plen = 16'hFFF0 | 16'($urandom_range(0, 15));
            send_pkt(d, $urandom_range(1, 5));
        end
        drain(6000);
        thr = 0; rmode = 0;

        // Scenario 6: asynchronous reset during the payload
        send_pkt(mk(2'd3, 1'b0, 1'b0, 16'h0101, 16'h0202, 16'd64, 64'd0), 8);
        got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (eq.size() <= 6) begin got = 1; break; end
        end
        chk("s6_in_body", 65'(got), 65'(1));
        @(posedge clk);
        #3 reset_n = 1'b0;
        eq.delete(); pq.delete(); dq.delete();
        i_tvalid = 1'b0; hdr_tvalid = 1'b0;
        #1;
        chk_outputs_zero("mid_pkt_reset");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        mseq = SEQ_INIT;
        send_pkt(mk(2'd1, 1'b1, 1'b0, 16'h0303, 16'h0404, 16'd8, 64'd0), 2);
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
